// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the data-memory responder
package dmem_pkg;
  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {LOAD, STORE, ILLEGAL} kind_e;
  function automatic kind_e classify(input logic rden, input logic wren, input logic legal_addr);
    return (!legal_addr || rden == wren) ? ILLEGAL : rden ? LOAD : STORE;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between core and data memory
interface dmem_responder_if #(
  parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W,
  parameter int DATA_W = dmem_pkg::DMEM_DATA_W
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_rden;
  logic              req_wren;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport master (
    output req_valid, req_rden, req_wren, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_rden, req_wren, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port word array with write enable and registered read port
module dmem_array #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W,
  parameter int DATA_W = dmem_pkg::DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  idx;
  assign idx = addr_i[IDX_W-1:0];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: services load/store requests from an internal array after
// a programmable number of wait states, one request in flight at a time
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input logic clk,
  input logic rst,
  dmem_responder_if.slave bus
);
  localparam int CNT_W = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, c_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, c_wdata, arr_rdata;
  logic              rden_q, rden_d, wren_q, wren_d, c_rden, c_wren;
  logic              err_q, err_d, load_q, load_d;
  logic              commit, we, re;
  kind_e             kind;
  // With zero wait states the commit happens on the accept edge, so the live request is used
  always_comb begin
    c_addr  = state_q == IDLE ? bus.req_addr  : addr_q;
    c_wdata = state_q == IDLE ? bus.req_wdata : wdata_q;
    c_rden  = state_q == IDLE ? bus.req_rden  : rden_q;
    c_wren  = state_q == IDLE ? bus.req_wren  : wren_q;
    kind    = classify(c_rden, c_wren, 32'(c_addr) < DEPTH);
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rden_d  = rden_q;
    wren_d  = wren_q;
    err_d   = err_q;
    load_d  = load_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        rden_d  = bus.req_rden;
        wren_d  = bus.req_wren;
        if (WAIT_STATES == 0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = CNT_W'(WAIT_STATES - 1);
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == '0) begin
        commit  = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      RESP: if (bus.rsp_ready) begin
        state_d = IDLE;
        err_d   = 1'b0;
        load_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d  = kind == ILLEGAL;
      load_d = kind == LOAD;
    end
    we = commit && !rst && kind == STORE;
    re = commit && !rst && kind == LOAD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rden_q  <= rden_d;
      wren_q  <= wren_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end
  dmem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk    (clk),
    .we_i   (we),
    .re_i   (re),
    .addr_i (c_addr),
    .wdata_i(c_wdata),
    .rdata_o(arr_rdata)
  );
  // Array output only changes on a load commit, so gating it keeps rsp_rdata stable and zero otherwise
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = load_q ? arr_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of three responder configurations
module tb_dmem_responder;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_rden = 0, req_wren = 0, rsp_ready = 0;
  logic [9:0]  req_addr = 0;
  logic [31:0] req_wdata = 0;
  int          sel = 0, checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  logic        ready, rvalid, rerr;
  logic [31:0] rdata;
  logic [31:0] mdl [32];
  logic        mv [32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if #(.ADDR_W(10), .DATA_W(32)) b0 ();
  dmem_responder_if #(.ADDR_W(10), .DATA_W(32)) b1 ();
  dmem_responder_if #(.ADDR_W(10), .DATA_W(32)) b2 ();

  dmem_responder #(.WAIT_STATES(2), .DEPTH(1024)) u0 (.clk(clk), .rst(rst), .bus(b0));
  dmem_responder #(.WAIT_STATES(0), .DEPTH(1024)) u1 (.clk(clk), .rst(rst), .bus(b1));
  dmem_responder #(.WAIT_STATES(2), .DEPTH(512))  u2 (.clk(clk), .rst(rst), .bus(b2));

  assign b0.req_valid = req_valid && sel == 0;
  assign b1.req_valid = req_valid && sel == 1;
  assign b2.req_valid = req_valid && sel == 2;
  assign b0.rsp_ready = rsp_ready && sel == 0;
  assign b1.rsp_ready = rsp_ready && sel == 1;
  assign b2.rsp_ready = rsp_ready && sel == 2;
  assign b0.req_rden = req_rden;
  assign b1.req_rden = req_rden;
  assign b2.req_rden = req_rden;
  assign b0.req_wren = req_wren;
  assign b1.req_wren = req_wren;
  assign b2.req_wren = req_wren;
  assign b0.req_addr = req_addr;
  assign b1.req_addr = req_addr;
  assign b2.req_addr = req_addr;
  assign b0.req_wdata = req_wdata;
  assign b1.req_wdata = req_wdata;
  assign b2.req_wdata = req_wdata;
  assign ready  = sel == 0 ? b0.req_ready : sel == 1 ? b1.req_ready : b2.req_ready;
  assign rvalid = sel == 0 ? b0.rsp_valid : sel == 1 ? b1.rsp_valid : b2.rsp_valid;
  assign rdata  = sel == 0 ? b0.rsp_rdata : sel == 1 ? b1.rsp_rdata : b2.rsp_rdata;
  assign rerr   = sel == 0 ? b0.rsp_err   : sel == 1 ? b1.rsp_err   : b2.rsp_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents a request at a negedge and returns at the negedge after the accept edge
  task automatic issue(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
    int n = 0;
    req_rden = rd; req_wren = wr; req_addr = a; req_wdata = d; req_valid = 1;
    #1;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    chk("accept", ready, 1);
    @(negedge clk);
    acc_cyc = cyc;
    req_valid = 0;
  endtask

  task automatic get_rsp(input string tag, input logic [31:0] ed, input logic ee, input int lat, input int stall);
    int n = 0;
    if (stall > 0) rsp_ready = 0;
    while (!rvalid && n < 20) begin
      chk({tag, "_busy_ready"}, ready, 0);
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, rvalid, 1);
    if (lat > 0) chk({tag, "_lat"}, n + 1, lat);
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_err"}, rerr, ee);
    chk({tag, "_resp_ready"}, ready, 0);
    repeat (stall) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, rvalid, 1);
      chk({tag, "_hold_rdata"}, rdata, ed);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk({tag, "_done_valid"}, rvalid, 0);
    chk({tag, "_done_ready"}, ready, 1);
  endtask

  initial begin
    int a1, a2;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_valid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", rerr, 0);
    end
    @(negedge clk);
    // 1: store then load with two wait states
    sel = 0;
    issue(0, 1, 5, 32'hDEADBEEF);
    get_rsp("t1_st", 0, 0, 3, 0);
    issue(1, 0, 5, 0);
    get_rsp("t1_ld", 32'hDEADBEEF, 0, 3, 0);
    // 3: backpressure with a second request waiting
    issue(1, 0, 5, 0);
    req_rden = 0; req_wren = 1; req_addr = 9; req_wdata = 32'h99; req_valid = 1;
    for (int n = 0; n < 20 && !rvalid; n++) @(negedge clk);
    chk("t3_valid", rvalid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", rvalid, 1);
      chk("t3_hold_rdata", rdata, 32'hDEADBEEF);
      chk("t3_hold_ready", ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("t3_idle_ready", ready, 1);
    chk("t3_idle_valid", rvalid, 0);
    @(negedge clk);
    req_valid = 0;
    chk("t3_second_accepted", ready, 0);
    get_rsp("t3_st", 0, 0, 3, 0);
    // 2: zero wait states, rsp_ready tied high
    sel = 1;
    rsp_ready = 1;
    issue(0, 1, 1023, 32'h0000_0001);
    a1 = acc_cyc;
    get_rsp("t2_st", 0, 0, 1, 0);
    rsp_ready = 1;
    issue(1, 0, 1023, 0);
    a2 = acc_cyc;
    chk("t2_spacing", a2 - a1, 2);
    get_rsp("t2_ld", 32'h0000_0001, 0, 1, 0);
    // 4: illegal requests on a 512-word array
    sel = 2;
    issue(0, 1, 0, 32'hA5A5_0000);
    get_rsp("t4_st", 0, 0, 3, 0);
    issue(1, 0, 600, 0);
    get_rsp("t4_oob", 0, 1, 3, 1);
    issue(1, 1, 0, 32'hFFFF_FFFF);
    get_rsp("t4_both", 0, 1, 3, 0);
    issue(0, 0, 0, 32'h1111_1111);
    get_rsp("t4_none", 0, 1, 3, 0);
    issue(1, 0, 0, 0);
    get_rsp("t4_ld0", 32'hA5A5_0000, 0, 3, 0);
    // 5: reset while a store is still waiting
    sel = 0;
    issue(0, 1, 7, 32'h0BAD_F00D);
    get_rsp("t5_st", 0, 0, 3, 0);
    issue(0, 1, 7, 32'h1234_5678);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t5_rst_valid", rvalid, 0);
    chk("t5_rst_ready", ready, 1);
    repeat (3) @(negedge clk);
    chk("t5_no_late_rsp", rvalid, 0);
    issue(1, 0, 7, 0);
    get_rsp("t5_ld", 32'h0BAD_F00D, 0, 3, 0);
    // 6: random store/load mix against a model
    for (int i = 0; i < 32; i++) mv[i] = 0;
    mdl[5] = 32'hDEADBEEF; mv[5] = 1;
    mdl[7] = 32'h0BAD_F00D; mv[7] = 1;
    mdl[9] = 32'h99; mv[9] = 1;
    for (int i = 0; i < 200; i++) begin
      int a, st;
      logic [31:0] d;
      a = $urandom_range(0, 31);
      st = $urandom_range(0, 3);
      d = $urandom;
      if ($urandom_range(0, 1) == 1 && mv[a]) begin
        issue(1, 0, 10'(a), 0);
        get_rsp("rnd_ld", mdl[a], 0, 3, st);
      end else begin
        issue(0, 1, 10'(a), d);
        mdl[a] = d;
        mv[a] = 1;
        get_rsp("rnd_st", 0, 0, 3, st);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
